// File: rtl/decode_branch_unit.sv
// IF/ID pipeline register with same-cycle branch resolution for B/BR and
// saturating branch / mispredict performance counters.
module decode_branch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [15:0] PC_curr,
  input  logic [15:0] PC_inst,
  input  logic [1:0]  prediction,
  input  logic [15:0] predicted_target,
  input  logic [2:0]  flags,
  input  logic [15:0] BR_reg_data,
  output logic [15:0] IF_ID_PC_curr,
  output logic [15:0] IF_ID_inst,
  output logic [15:0] IF_ID_predicted_target,
  output logic [1:0]  IF_ID_prediction,
  output logic        IF_ID_valid,
  output logic        actual_taken,
  output logic        wen_BTB,
  output logic        wen_BHT,
  output logic        update_PC,
  output logic [15:0] actual_target,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count
);

  localparam logic [3:0] OP_B  = 4'hC;
  localparam logic [3:0] OP_BR = 4'hD;

  logic        is_b, is_br, resolved, cond_true;
  logic        mispredicted, miscomputed;
  logic        z_f, n_f, v_f;
  logic [2:0]  cond;
  logic [8:0]  imm9;
  logic [15:0] seq_pc, b_target, comp_target;

  assign is_b  = (IF_ID_inst[15:12] == OP_B);
  assign is_br = (IF_ID_inst[15:12] == OP_BR);
  assign cond  = IF_ID_inst[11:9];
  assign imm9  = IF_ID_inst[8:0];
  assign {z_f, n_f, v_f} = flags;

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'b000: cond_true = ~z_f;
      3'b001: cond_true = z_f;
      3'b010: cond_true = ~z_f & ~n_f;
      3'b011: cond_true = n_f;
      3'b100: cond_true = z_f | (~z_f & ~n_f);
      3'b101: cond_true = n_f | z_f;
      3'b110: cond_true = v_f;
      3'b111: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // Offsets are halfword-scaled; all sums wrap at 16 bits.
  assign seq_pc      = IF_ID_PC_curr + 16'd2;
  assign b_target    = seq_pc + {{6{imm9[8]}}, imm9, 1'b0};
  assign comp_target = is_br ? BR_reg_data : b_target;

  // Stall defers resolution so a held branch resolves exactly once.
  assign resolved     = IF_ID_valid & ~stall & (is_b | is_br);
  assign actual_taken = resolved & cond_true;
  assign actual_target = actual_taken ? comp_target : seq_pc;

  assign mispredicted = (IF_ID_prediction[1] != actual_taken);
  assign miscomputed  = (IF_ID_predicted_target != comp_target);

  assign wen_BHT   = resolved & mispredicted;
  assign wen_BTB   = resolved & (actual_taken | miscomputed);
  assign update_PC = resolved & (mispredicted | (actual_taken & miscomputed));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IF_ID_PC_curr          <= 16'h0000;
      IF_ID_inst             <= 16'h0000;
      IF_ID_predicted_target <= 16'h0000;
      IF_ID_prediction       <= 2'b00;
      IF_ID_valid            <= 1'b0;
    end else if (!stall) begin
      IF_ID_PC_curr          <= PC_curr;
      IF_ID_predicted_target <= predicted_target;
      IF_ID_prediction       <= prediction;
      if (update_PC) begin
        IF_ID_valid <= 1'b0;
        IF_ID_inst  <= 16'h0000;
      end else begin
        IF_ID_valid <= 1'b1;
        IF_ID_inst  <= PC_inst;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count     <= 16'h0000;
      mispredict_count <= 16'h0000;
    end else begin
      if (resolved && branch_count != 16'hFFFF)
        branch_count <= branch_count + 16'd1;
      if (update_PC && mispredict_count != 16'hFFFF)
        mispredict_count <= mispredict_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_decode_branch_unit.sv
// Self-checking bench for decode_branch_unit: directed table, stall/reset
// sequences, randomized run against a reference model, counter saturation.
module tb_decode_branch_unit;

  logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0;
  logic [15:0] PC_curr = '0, PC_inst = '0, predicted_target = '0, BR_reg_data = '0;
  logic [1:0]  prediction = '0;
  logic [2:0]  flags = '0;
  logic [15:0] IF_ID_PC_curr, IF_ID_inst, IF_ID_predicted_target;
  logic [1:0]  IF_ID_prediction;
  logic        IF_ID_valid, actual_taken, wen_BTB, wen_BHT, update_PC;
  logic [15:0] actual_target, branch_count, mispredict_count;

  decode_branch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .PC_curr(PC_curr), .PC_inst(PC_inst), .prediction(prediction),
    .predicted_target(predicted_target), .flags(flags), .BR_reg_data(BR_reg_data),
    .IF_ID_PC_curr(IF_ID_PC_curr), .IF_ID_inst(IF_ID_inst),
    .IF_ID_predicted_target(IF_ID_predicted_target), .IF_ID_prediction(IF_ID_prediction),
    .IF_ID_valid(IF_ID_valid), .actual_taken(actual_taken), .wen_BTB(wen_BTB),
    .wen_BHT(wen_BHT), .update_PC(update_PC), .actual_target(actual_target),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  typedef struct {
    logic [15:0] pc, inst;
    logic [1:0]  pred;
    logic [15:0] pt;
    logic [2:0]  fl;
    logic [15:0] br;
    logic        taken;
    logic [15:0] tgt;
    logic        upd, bht, btb;
  } vec_t;

  typedef struct {
    logic        res, taken, upd, bht, btb;
    logic [15:0] tgt;
  } res_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] pc, input logic [15:0] inst, input logic [1:0] pr,
                       input logic [15:0] pt, input logic [2:0] fl, input logic [15:0] br,
                       input logic st);
    PC_curr = pc; PC_inst = inst; prediction = pr; predicted_target = pt;
    flags = fl; BR_reg_data = br; stall = st;
  endtask

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] b_tgt(input logic [15:0] pc, input logic [8:0] imm);
    int off;
    off = int'(imm);
    if (off >= 256) off -= 512;
    return 16'((int'(pc) + 2 + 2 * off + 65536) % 65536);
  endfunction

  // Reference: derived directly from the branch rules as plain arithmetic.
  function automatic res_t ref_res(input logic v, input logic [15:0] pc, input logic [15:0] inst,
                                   input logic [1:0] pr, input logic [15:0] pt, input logic st,
                                   input logic [2:0] fl, input logic [15:0] br);
    res_t r;
    logic z, n, vf, c;
    logic [15:0] comp, seq;
    z = fl[2]; n = fl[1]; vf = fl[0];
    case (inst[11:9])
      3'd0: c = !z;
      3'd1: c = z;
      3'd2: c = !z && !n;
      3'd3: c = n;
      3'd4: c = z || (!z && !n);
      3'd5: c = n || z;
      3'd6: c = vf;
      default: c = 1'b1;
    endcase
    seq  = 16'((int'(pc) + 2) % 65536);
    comp = (inst[15:12] == 4'hD) ? br : b_tgt(pc, inst[8:0]);
    r.res   = v && !st && (inst[15:12] == 4'hC || inst[15:12] == 4'hD);
    r.taken = r.res && c;
    r.tgt   = r.taken ? comp : seq;
    r.bht   = r.res && (pr[1] != r.taken);
    r.btb   = r.res && (r.taken || pt != comp);
    r.upd   = r.res && ((pr[1] != r.taken) || (r.taken && pt != comp));
    return r;
  endfunction

  task automatic mispredict_once;
    drive(16'h0010, 16'hCE04, 2'b00, 16'h0000, 3'b000, 16'h0000, 1'b0); cyc;
    drive(16'h0012, 16'h0000, 2'b00, 16'h0000, 3'b000, 16'h0000, 1'b0); cyc;
  endtask

  vec_t vecs[12];
  int   exp_bc, exp_mc;

  initial begin
    vecs[0]  = '{16'h0010, 16'hCE04, 2'b00, 16'h0000, 3'b000, 16'h0000, 1'b1, 16'h001A, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{16'h0020, 16'hC208, 2'b10, 16'h0040, 3'b000, 16'h0000, 1'b0, 16'h0022, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{16'h0100, 16'hDE00, 2'b11, 16'h1234, 3'b000, 16'h1234, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{16'hFFFE, 16'hC000, 2'b00, 16'h0000, 3'b100, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{16'hFFFE, 16'hCFFF, 2'b11, 16'hFFFE, 3'b000, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{16'h0200, 16'hC400, 2'b00, 16'h0000, 3'b000, 16'h0000, 1'b1, 16'h0202, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{16'h0300, 16'hC602, 2'b10, 16'h0306, 3'b010, 16'h0000, 1'b1, 16'h0306, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{16'h0400, 16'hC9FE, 2'b10, 16'h03FE, 3'b100, 16'h0000, 1'b1, 16'h03FE, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{16'h0500, 16'hCA00, 2'b00, 16'h0502, 3'b000, 16'h0000, 1'b0, 16'h0502, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{16'h0600, 16'hDC00, 2'b10, 16'h1111, 3'b001, 16'hBEEF, 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{16'h0700, 16'h1234, 2'b10, 16'h0000, 3'b000, 16'h0000, 1'b0, 16'h0702, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{16'h0800, 16'hC000, 2'b11, 16'h0900, 3'b000, 16'h0000, 1'b1, 16'h0802, 1'b1, 1'b0, 1'b1};

    // Reset state, with busy inputs and clock edges while held in reset
    drive(16'hABCD, 16'hCE04, 2'b11, 16'h5555, 3'b111, 16'h7777, 1'b0);
    #12;
    chk("rst_ifid", {IF_ID_valid, IF_ID_inst, IF_ID_PC_curr, IF_ID_predicted_target, IF_ID_prediction}, 64'h0);
    chk("rst_res", {actual_taken, update_PC, wen_BHT, wen_BTB, actual_target}, {4'b0000, 16'h0002});
    chk("rst_cnt", {branch_count, mispredict_count}, 32'h0);
    drive(16'h0000, 16'h0000, 2'b00, 16'h0000, 3'b000, 16'h0000, 1'b0);
    rst_n = 1'b1;

    // Directed table
    exp_bc = 0; exp_mc = 0;
    foreach (vecs[i]) begin
      drive(vecs[i].pc, vecs[i].inst, vecs[i].pred, vecs[i].pt, vecs[i].fl, vecs[i].br, 1'b0);
      cyc;
      drive(vecs[i].pc + 16'd2, 16'h0000, 2'b00, 16'h0000, vecs[i].fl, vecs[i].br, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d", i), {actual_taken, update_PC, wen_BHT, wen_BTB, actual_target},
          {vecs[i].taken, vecs[i].upd, vecs[i].bht, vecs[i].btb, vecs[i].tgt});
      if (vecs[i].inst[15:12] == 4'hC || vecs[i].inst[15:12] == 4'hD) exp_bc++;
      if (vecs[i].upd) exp_mc++;
      cyc;
      if (i == 0) chk("flush_valid", {IF_ID_valid, IF_ID_inst}, {1'b0, 16'h0000});
    end
    chk("tbl_cnt", {branch_count, mispredict_count}, {16'(exp_bc), 16'(exp_mc)});

    // Mispredicting branch held by stall for three cycles
    drive(16'h0010, 16'hCE04, 2'b00, 16'h0000, 3'b000, 16'h0000, 1'b0); cyc;
    drive(16'h1111, 16'h1111, 2'b11, 16'h2222, 3'b000, 16'h0000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_res", {actual_taken, update_PC, wen_BHT, wen_BTB}, 4'b0000);
      chk("stall_hold", {IF_ID_valid, IF_ID_inst, IF_ID_PC_curr}, {1'b1, 16'hCE04, 16'h0010});
      chk("stall_cnt", {branch_count, mispredict_count}, {16'(exp_bc), 16'(exp_mc)});
      cyc;
    end
    stall = 1'b0;
    @(negedge clk);
    chk("unstall_res", {actual_taken, update_PC, actual_target}, {2'b11, 16'h001A});
    cyc;
    exp_bc++; exp_mc++;
    @(negedge clk);
    chk("unstall_flush", {IF_ID_valid, IF_ID_inst, IF_ID_PC_curr, update_PC}, {1'b0, 16'h0000, 16'h1111, 1'b0});
    chk("unstall_cnt", {branch_count, mispredict_count}, {16'(exp_bc), 16'(exp_mc)});
    cyc;
    chk("unstall_once", {branch_count, mispredict_count}, {16'(exp_bc), 16'(exp_mc)});

    // Async reset mid-stall discards held branch
    drive(16'h0030, 16'hCE04, 2'b00, 16'h0000, 3'b000, 16'h0000, 1'b0); cyc;
    stall = 1'b1; cyc;
    rst_n = 1'b0; #1;
    chk("rst_mid_ifid", {IF_ID_valid, IF_ID_inst, IF_ID_PC_curr}, 33'h0);
    chk("rst_mid_res", {update_PC, actual_target, branch_count, mispredict_count}, {1'b0, 16'h0002, 32'h0});
    rst_n = 1'b1;
    drive(16'h0050, 16'h1234, 2'b01, 16'h0060, 3'b000, 16'h0000, 1'b0); cyc;
    chk("post_rst_load", {IF_ID_valid, IF_ID_inst, IF_ID_PC_curr, IF_ID_prediction}, {1'b1, 16'h1234, 16'h0050, 2'b01});

    // Randomized run against the reference model
    begin
      logic [15:0] m_pc, m_inst, m_pt, pc, inst, pt, br;
      logic [1:0]  m_pred, pr;
      logic [2:0]  fl;
      logic        m_v, st;
      int          m_bc, m_mc;
      res_t        r;
      drive(16'h0, 16'h0, 2'b00, 16'h0, 3'b000, 16'h0, 1'b0);
      rst_n = 1'b0; #1; rst_n = 1'b1;
      m_pc = '0; m_inst = '0; m_pt = '0; m_pred = '0; m_v = 1'b0; m_bc = 0; m_mc = 0;
      for (int i = 0; i < 400; i++) begin
        pc   = 16'($urandom);
        inst = ($urandom_range(0, 3) != 0) ? {($urandom_range(0, 1) != 0) ? 4'hC : 4'hD, 12'($urandom)}
                                           : 16'($urandom);
        br   = ($urandom_range(0, 1) != 0) ? 16'h1234 : 16'h4321;
        case ($urandom_range(0, 2))
          0: pt = 16'($urandom);
          1: pt = b_tgt(pc, inst[8:0]);
          default: pt = 16'h1234;
        endcase
        pr = 2'($urandom);
        fl = 3'($urandom);
        st = ($urandom_range(0, 3) == 0);
        drive(pc, inst, pr, pt, fl, br, st);
        @(negedge clk);
        r = ref_res(m_v, m_pc, m_inst, m_pred, m_pt, st, fl, br);
        chk("rand_res", {actual_taken, update_PC, wen_BHT, wen_BTB, actual_target},
            {r.taken, r.upd, r.bht, r.btb, r.tgt});
        chk("rand_ifid", {IF_ID_valid, IF_ID_inst, IF_ID_PC_curr, IF_ID_predicted_target, IF_ID_prediction},
            {m_v, m_inst, m_pc, m_pt, m_pred});
        chk("rand_cnt", {branch_count, mispredict_count}, {16'(m_bc), 16'(m_mc)});
        if (!st) begin
          m_pc = pc; m_pt = pt; m_pred = pr;
          m_v  = !r.upd;
          m_inst = r.upd ? 16'h0000 : inst;
        end
        if (r.res && m_bc < 65535) m_bc++;
        if (r.upd && m_mc < 65535) m_mc++;
        cyc;
      end
    end

    // Saturation of mispredict_count, then reset without a clock edge
    rst_n = 1'b0; #1; rst_n = 1'b1;
    force dut.mispredict_count = 16'hFFFD;
    #1;
    release dut.mispredict_count;
    mispredict_once;
    mispredict_once;
    chk("sat_reach", {branch_count, mispredict_count}, {16'd2, 16'hFFFF});
    mispredict_once;
    chk("sat_hold", {branch_count, mispredict_count}, {16'd3, 16'hFFFF});
    rst_n = 1'b0; #1;
    chk("sat_async_rst", {branch_count, mispredict_count}, 32'h0);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_branch_unit.md
DECODE_BRANCH_UNIT -- requirements
Module: decode_branch_unit

Interface
REQ-001 SHALL provide: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL provide: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide: stall  input  1  when 1, hold all IF/ID state and suppress branch resolution.
REQ-004 SHALL provide: PC_curr, PC_inst  input  16 each  Fetch stage PC and instruction.
REQ-005 SHALL provide: prediction  input  2  Fetch BHT counter; bit 1 is predicted taken.
REQ-006 SHALL provide: predicted_target  input  16  Fetch BTB target.
REQ-007 SHALL provide: flags  input  3  {Z,N,V} from the flag register.
REQ-008 SHALL provide: BR_reg_data  input  16  register-file value for BR.
REQ-009 SHALL provide: IF_ID_PC_curr, IF_ID_inst, IF_ID_predicted_target  output  16 each  registered Fetch values.
REQ-010 SHALL provide: IF_ID_prediction  output  2; IF_ID_valid  output  1.
REQ-011 SHALL provide: actual_taken, wen_BTB, wen_BHT, update_PC  output  1 each  resolution results to Fetch.
REQ-012 SHALL provide: actual_target  output  16  redirect address.
REQ-013 SHALL provide: branch_count, mispredict_count  output  16 each  performance counters.

Function
REQ-014 IF/ID register: stall=1 -> hold; stall=0 and update_PC=1 -> IF_ID_valid<=0, IF_ID_inst<=16'h0000, other fields load; stall=0 otherwise -> load all fields, IF_ID_valid<=1.
REQ-015 Branch decode: IF_ID_inst[15:12]=4'hC is B (cond [11:9], imm9 [8:0]); 4'hD is BR (cond [11:9]); resolved = IF_ID_valid & ~stall & (B|BR).
REQ-016 Conditions: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
REQ-017 actual_taken = resolved & condition true; 0 whenever not resolved.
REQ-018 Computed target: B -> IF_ID_PC_curr + 2 + (sext(imm9)<<1); BR -> BR_reg_data; all sums modulo 2^16.
REQ-019 actual_target = computed target when actual_taken, else IF_ID_PC_curr + 2 (0xFFFE wraps to 0x0000).
REQ-020 mispredicted = IF_ID_prediction[1] != actual_taken; miscomputed = IF_ID_predicted_target != computed target.
REQ-021 wen_BHT = resolved & mispredicted.
REQ-022 wen_BTB = resolved & (actual_taken | miscomputed).
REQ-023 update_PC = resolved & (mispredicted | (actual_taken & miscomputed)); same-cycle combinational, zero latency.
REQ-024 Predicted taken but not taken SHALL redirect to IF_ID_PC_curr + 2 via update_PC.
REQ-025 Squashed slot (IF_ID_valid=0) SHALL never assert wen_BTB, wen_BHT, update_PC or actual_taken.
REQ-026 branch_count +1 per cycle with resolved=1; mispredict_count +1 per cycle with update_PC=1; both saturate at 16'hFFFF.
REQ-027 Stall asserted while a branch sits in IF/ID: resolution deferred; resolves once, in the first cycle stall=0.
REQ-028 Stall and a would-be mispredict in the same cycle: no flush, no writes, no counter change.

Reset
REQ-029 rst_n=0 SHALL immediately clear all IF_ID outputs, IF_ID_valid and both counters to 0, independent of clk.
REQ-030 During and after reset until the first load, all resolution outputs are 0 and actual_target = 16'h0002.
REQ-031 Reset mid-stall or mid-flush SHALL discard held state; the first post-reset edge with stall=0 loads normally.

Verification
REQ-032 B cond=111, imm9=9'h004, PC=0x0010, prediction=00 -> actual_taken=1, actual_target=0x001A, update_PC=1, wen_BHT=1, wen_BTB=1; next cycle IF_ID_valid=0.
REQ-033 B cond=001, Z=0, prediction=10, predicted_target=0x0040, PC=0x0020 -> actual_taken=0, actual_target=0x0022, update_PC=1, wen_BHT=1, wen_BTB=1.
REQ-034 BR cond=111, BR_reg_data=0x1234, prediction=11, predicted_target=0x1234 -> update_PC=0, wen_BHT=0, wen_BTB=1, branch_count+1, mispredict_count unchanged.
REQ-035 Mispredicting branch with stall=1 for 3 cycles -> no outputs, IF/ID held; stall=0 -> one update_PC pulse, counters +1 once.
REQ-036 PC=0xFFFE, B cond=000 with Z=1 -> actual_target=0x0000; imm9=9'h1FF taken -> target 0xFFFE.
REQ-037 mispredict_count preloaded to 0xFFFF by 65535 mispredicts, one more -> stays 0xFFFF; rst_n pulse -> 0x0000 without a clk edge.
